stopwatch_ctrl: RTL

Controller that sequences the stopwatch datapath. It consumes single-cycle tick enables from the system frequency divider: 1 Hz for counting, 100 Hz for button sampling. It debounces and one-pulses two raw buttons, runs a start/pause/lap/clear state machine, and maintains an MM:SS BCD count. Its output is the four display digits consumed by the seven-segment scan logic.

---
 rtl/stopwatch_ctrl_if.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller port bundle: tick/button inputs and display/status outputs.
// Latency: none (wiring only).
// Backpressure: none; ticks and buttons are fire-and-forget, outputs are always valid.
//
// Signals:
//   tick_1hz, tick_100hz  single-cycle tick enables from the frequency divider
//   btn_start, btn_lap    raw synchronised buttons, active high
//   disp_*                four BCD display digits (MM:SS)
//   state, running        FSM state (IDLE=0 RUN=1 PAUSE=2 LAP=3) and run flag
//   overflow              one-cycle pulse on MAX_MIN:59 -> 00:00 wrap
// master = tick/button source side, slave = the controller.
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_100hz;
  logic       btn_start;
  logic       btn_lap;
  logic [3:0] disp_min_t;
  logic [3:0] disp_min_o;
  logic [3:0] disp_sec_t;
  logic [3:0] disp_sec_o;
  logic [1:0] state;
  logic       running;
  logic       overflow;

  modport master (
    output tick_1hz, tick_100hz, btn_start, btn_lap,
    input  disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, state, running, overflow
  );

  modport slave (
    input  tick_1hz, tick_100hz, btn_start, btn_lap,
    output disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, state, running, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button debounce/one-pulse, start/pause/lap/clear FSM, MM:SS BCD count.
// Latency: state change 2 clk edges after the edge that completes a debounced press; outputs registered.
// Backpressure: none; every tick and press is consumed in the cycle it is seen.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   sw     stopwatch_ctrl_if.slave (ticks and buttons in; display digits, state, running, overflow out)
module stopwatch_ctrl #(
  parameter int DEB_LEN = 4,   // consecutive 100 Hz samples for a level change (2-8)
  parameter int MAX_MIN = 59   // highest minute value before wrap (1-99)
) (
  input logic             clk,
  input logic             rst_n,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } mmss_t;

  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

  // ---------------------------------------------------------------------------
  // Debounce and one-pulse. Index 0 = start button, index 1 = lap button.
  // ---------------------------------------------------------------------------
  logic [1:0]              raw;
  logic [1:0][DEB_LEN-1:0] deb_sh;
  logic [1:0]              deb_lvl;
  logic [1:0]              deb_q;
  logic [1:0]              press;
  logic                    start_p;
  logic                    lap_p;

  assign raw = {sw.btn_lap, sw.btn_start};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_sh  <= '0;
      deb_lvl <= '0;
      deb_q   <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sw.tick_100hz) begin
          deb_sh[b] <= {deb_sh[b][DEB_LEN-2:0], raw[b]};
        end
        // Level follows a full run of identical samples, otherwise holds.
        if (&deb_sh[b]) begin
          deb_lvl[b] <= 1'b1;
        end else if (~|deb_sh[b]) begin
          deb_lvl[b] <= 1'b0;
        end
      end
      deb_q <= deb_lvl;
    end
  end

  assign press   = deb_lvl & ~deb_q;
  assign start_p = press[0];
  // Start has priority; a simultaneous lap press is dropped.
  assign lap_p   = press[1] & ~press[0];

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   snap_take;
  logic   clear_live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_take  = 1'b0;
    clear_live = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_p) state_d = RUN;
      end
      RUN: begin
        if (start_p) begin
          state_d = PAUSE;
        end else if (lap_p) begin
          state_d   = LAP;
          snap_take = 1'b1;
        end
      end
      LAP: begin
        if (start_p) begin
          state_d = PAUSE;
        end else if (lap_p) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (start_p) begin
          state_d = RUN;
        end else if (lap_p) begin
          state_d    = IDLE;
          clear_live = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Live count and lap snapshot
  // ---------------------------------------------------------------------------
  mmss_t live_q;
  mmss_t live_d;
  mmss_t live_inc;
  mmss_t snap_q;
  mmss_t snap_d;
  mmss_t disp_q;
  logic  at_max;
  logic  count_en;
  logic  running_q;
  logic  overflow_q;

  // Counting is qualified by the state before the edge, so a tick that
  // coincides with leaving RUN/LAP is counted and one that coincides with
  // entering RUN is not.
  assign count_en = sw.tick_1hz && ((state_q == RUN) || (state_q == LAP));

  assign at_max = (live_q.min_t == MAX_MT) && (live_q.min_o == MAX_MO) &&
                  (live_q.sec_t == 4'd5)   && (live_q.sec_o == 4'd9);

  // BCD ripple increment; min_t cannot pass 9 because at_max wraps first.
  always_comb begin
    live_inc = live_q;
    if (at_max) begin
      live_inc = '0;
    end else if (live_q.sec_o != 4'd9) begin
      live_inc.sec_o = live_q.sec_o + 4'd1;
    end else begin
      live_inc.sec_o = 4'd0;
      if (live_q.sec_t != 4'd5) begin
        live_inc.sec_t = live_q.sec_t + 4'd1;
      end else begin
        live_inc.sec_t = 4'd0;
        if (live_q.min_o != 4'd9) begin
          live_inc.min_o = live_q.min_o + 4'd1;
        end else begin
          live_inc.min_o = 4'd0;
          live_inc.min_t = live_q.min_t + 4'd1;
        end
      end
    end
  end

  always_comb begin
    live_d = live_q;
    if (clear_live) begin
      live_d = '0;
    end else if (count_en) begin
      live_d = live_inc;
    end
    // Snapshot takes the count as it stood before this edge.
    snap_d = snap_take ? live_q : snap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= '0;
      snap_q     <= '0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      live_q     <= live_d;
      snap_q     <= snap_d;
      // Display is chosen from the next state so digits and state change together.
      disp_q     <= (state_d == LAP) ? snap_d : live_d;
      running_q  <= (state_d == RUN) || (state_d == LAP);
      overflow_q <= count_en && at_max;
    end
  end

  assign sw.disp_min_t = disp_q.min_t;
  assign sw.disp_min_o = disp_q.min_o;
  assign sw.disp_sec_t = disp_q.sec_t;
  assign sw.disp_sec_o = disp_q.sec_o;
  assign sw.state      = state_q;
  assign sw.running    = running_q;
  assign sw.overflow   = overflow_q;

endmodule
